// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: interrupt sources, mask config and processor handshake of irq_arbiter
interface irq_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
);
  logic [N_SRC-1:0] irq_src;
  logic             cfg_we;
  logic [N_SRC-1:0] cfg_enable;
  logic             ExtIAck;
  logic             eoi;
  logic             ExtIRQ;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] irq_pending;
  logic             busy;
  modport master (
    output irq_src, cfg_we, cfg_enable, ExtIAck, eoi,
    input  ExtIRQ, irq_id, irq_pending, busy
  );
  modport slave (
    input  irq_src, cfg_we, cfg_enable, ExtIAck, eoi,
    output ExtIRQ, irq_id, irq_pending, busy
  );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-latched, masked, prioritised interrupt funnel onto ExtIRQ/ExtIAck.
// Define IRQ_ROUND_ROBIN_EN for rotating arbitration instead of lowest-index-wins.
module irq_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input logic         CLOCK_50,
  input logic         reset,
  irq_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t           state_q, state_d;
  logic [N_SRC-1:0] src_q, pend_q, pend_d, en_q, en_d, cand, clr;
  logic             irq_q, irq_d, ack;
  logic [ID_W-1:0]  id_q, id_d, win;
  assign cand   = pend_q & en_q;
  assign ack    = (state_q == REQ) && bus.ExtIAck;
  assign clr    = ack ? N_SRC'(1) << id_q : '0;
  // a fresh edge outranks the acknowledge clear of the same bit
  assign pend_d = (pend_q & ~clr) | (bus.irq_src & ~src_q);
  assign en_d   = bus.cfg_we ? bus.cfg_enable : en_q;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_q;
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) last_q <= ID_W'(N_SRC - 1);
    else if (ack) last_q <= id_q;
  always_comb begin
    win = '0;
    for (int k = N_SRC; k >= 1; k--)
      if (cand[(int'(last_q) + k) % N_SRC]) win = ID_W'((int'(last_q) + k) % N_SRC);
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (cand[i]) win = ID_W'(i);
  end
`endif
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    case (state_q)
      IDLE: if (|cand) begin
        state_d = REQ;
        irq_d   = 1'b1;
        id_d    = win;
      end
      REQ: if (bus.ExtIAck) begin
        state_d = SERVICE;
        irq_d   = 1'b0;
      end
      SERVICE: if (bus.eoi) state_d = IDLE;
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      pend_q  <= '0;
      en_q    <= '1;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= bus.irq_src;
      pend_q  <= pend_d;
      en_q    <= en_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
    end
  assign bus.ExtIRQ      = irq_q;
  assign bus.irq_id      = id_q;
  assign bus.irq_pending = pend_q;
  assign bus.busy        = state_q != IDLE;
endmodule
